booth_mac_accum: RTL and testbench

//  Downstream consumer of the 4-bit signed booth_multiplier: accepts its 8-bit signed products over a

---
 rtl/booth_mac_pkg.sv | 33 +++
 rtl/booth_mac_accum.sv | 94 +++++++++
 tb/tb_booth_mac_accum.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_mac_pkg.sv
// Shared types and helpers for the booth product accumulator.
// sat_add is only referenced when BOOTH_MAC_SAT_EN is defined.
package booth_mac_pkg;

  localparam int PROD_W = 8;

  typedef enum logic {ACCUM, HOLD} mac_state_e;

  // Signed add clamped to a w-bit two's-complement range; ovf flags a clamp.
  function automatic logic signed [63:0] sat_add(
    input  logic signed [63:0] a,
    input  logic signed [63:0] b,
    input  int                 w,
    output logic               ovf
  );
    logic signed [64:0] sum;
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    sum = {a[63], a} + {b[63], b};
    hi  = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo  = -(65'sd1 <<< (w - 1));
    ovf = 1'b0;
    if (sum > hi) begin
      ovf = 1'b1;
      sum = hi;
    end else if (sum < lo) begin
      ovf = 1'b1;
      sum = lo;
    end
    return sum[63:0];
  endfunction

endpackage

// File: rtl/booth_mac_accum.sv
// Accumulates N_TERMS signed 8-bit products into one ACC_W result (saturating when BOOTH_MAC_SAT_EN).
// Latency: result valid the cycle after the final term is accepted.
// Backpressure: in_ready drops while a result is held until out_valid & out_ready; in_clear aborts.
module booth_mac_accum
  import booth_mac_pkg::*;
#(
  parameter int ACC_W   = 16,
  parameter int N_TERMS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_product,
  input  logic             in_clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf
);

  localparam int CNT_W = $clog2(N_TERMS + 1);

  mac_state_e              state;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;
  logic                    ovf;

  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] next_acc;
  logic                    add_ovf;
  logic                    accept;
  logic                    last_term;

  assign prod_ext  = ACC_W'($signed(in_product));
  assign accept    = (state == ACCUM) && in_valid && in_ready;
  assign last_term = (cnt == CNT_W'(N_TERMS - 1));

  always_comb begin
    add_ovf  = 1'b0;
    next_acc = acc;
`ifdef BOOTH_MAC_SAT_EN
    next_acc = ACC_W'(sat_add(64'(acc), 64'(prod_ext), ACC_W, add_ovf));
`else
    next_acc = acc + prod_ext;
`endif
  end

  // in_ready/out_valid are registered copies of the state decode.
  always_ff @(posedge clk) begin
    if (rst || in_clear) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc <= next_acc;
            cnt <= cnt + CNT_W'(1);
            ovf <= ovf | add_ovf;
            if (last_term) begin
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ACCUM;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_acc = acc;
  assign out_ovf = ovf;

endmodule

// File: tb/tb_booth_mac_accum.sv
// Randomized and directed bench for booth_mac_accum over three parameterisations.
module tb_booth_mac_accum;

  localparam int NT [3] = '{4, 4, 1};
  localparam int WD [3] = '{16, 8, 16};

  logic        clk;
  logic        rst;
  logic        vld  [3];
  logic        clr  [3];
  logic        ordy [3];
  logic [7:0]  prod [3];
  logic        irdy [3];
  logic        ovld [3];
  logic        ovf  [3];
  logic [15:0] acc0;
  logic [7:0]  acc1;
  logic [15:0] acc2;

  int checks = 0;
  int errors = 0;

  // reference model: accepted terms of the current result plus a holding flag
  int terms [3][$];
  bit hold  [3];
  bit took  [3];
  bit pend  [3];

  booth_mac_accum #(.ACC_W(16), .N_TERMS(4)) u0 (
    .clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(irdy[0]), .in_product(prod[0]),
    .in_clear(clr[0]), .out_valid(ovld[0]), .out_ready(ordy[0]), .out_acc(acc0), .out_ovf(ovf[0]));
  booth_mac_accum #(.ACC_W(8), .N_TERMS(4)) u1 (
    .clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(irdy[1]), .in_product(prod[1]),
    .in_clear(clr[1]), .out_valid(ovld[1]), .out_ready(ordy[1]), .out_acc(acc1), .out_ovf(ovf[1]));
  booth_mac_accum #(.ACC_W(16), .N_TERMS(1)) u2 (
    .clk(clk), .rst(rst), .in_valid(vld[2]), .in_ready(irdy[2]), .in_product(prod[2]),
    .in_clear(clr[2]), .out_valid(ovld[2]), .out_ready(ordy[2]), .out_acc(acc2), .out_ovf(ovf[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [31:0] get_acc(input int i);
    case (i)
      0:       return 32'($signed(acc0));
      1:       return 32'($signed(acc1));
      default: return 32'($signed(acc2));
    endcase
  endfunction

  // Expected result: plain integer sum of the accepted terms, clamped per add or wrapped.
  function automatic void ref_eval(input int i, output int s, output bit ov);
    int maxv;
    int minv;
    int m;
    maxv = (1 << (WD[i] - 1)) - 1;
    minv = -(1 << (WD[i] - 1));
    m    = 1 << WD[i];
    s    = 0;
    ov   = 1'b0;
    for (int k = 0; k < terms[i].size(); k++) begin
      s += terms[i][k];
`ifdef BOOTH_MAC_SAT_EN
      if (s > maxv) begin s = maxv; ov = 1'b1; end
      else if (s < minv) begin s = minv; ov = 1'b1; end
`endif
    end
`ifndef BOOTH_MAC_SAT_EN
    s = s % m;
    if (s > maxv) s -= m;
    else if (s < minv) s += m;
`endif
  endfunction

  task automatic model_update();
    for (int i = 0; i < 3; i++) begin
      took[i] = 1'b0;
      if (rst || clr[i]) begin
        terms[i].delete();
        hold[i] = 1'b0;
      end else if (!hold[i]) begin
        if (vld[i]) begin
          terms[i].push_back(int'($signed(prod[i])));
          took[i] = 1'b1;
          if (terms[i].size() == NT[i]) hold[i] = 1'b1;
        end
      end else if (ordy[i]) begin
        hold[i] = 1'b0;
        terms[i].delete();
      end
    end
  endtask

  task automatic check_all();
    int  s;
    bit  ov;
    for (int i = 0; i < 3; i++) begin
      ref_eval(i, s, ov);
      chk($sformatf("u%0d_in_ready", i), 32'(irdy[i]), 32'(!hold[i]));
      chk($sformatf("u%0d_out_valid", i), 32'(ovld[i]), 32'(hold[i]));
      chk($sformatf("u%0d_out_acc", i), get_acc(i), s);
      chk($sformatf("u%0d_out_ovf", i), 32'(ovf[i]), 32'(ov));
    end
  endtask

  // Inputs are already driven; advance model and DUT one cycle, then compare.
  task automatic step();
    model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic send(input int i, input int t);
    vld[i]  = 1'b1;
    prod[i] = 8'(t);
    for (int k = 0; k < 50; k++) begin
      step();
      if (took[i]) break;
    end
    if (!took[i]) chk("send_timeout", 0, 1);
    vld[i] = 1'b0;
  endtask

  function automatic int rand_term();
    if ($urandom_range(0, 1) == 0)
      return (int'($urandom_range(0, 15)) - 8) * (int'($urandom_range(0, 15)) - 8);
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vld[i] = 1'b0; clr[i] = 1'b0; ordy[i] = 1'b1; prod[i] = '0;
      hold[i] = 1'b0; took[i] = 1'b0; pend[i] = 1'b0;
    end
    @(negedge clk);
    step();
    step();
    chk("rst_in_ready", 32'(irdy[0]), 1);
    chk("rst_out_valid", 32'(ovld[0]), 0);
    chk("rst_acc", get_acc(0), 0);
    rst = 1'b0;

    // four booth products summing to 10, consumer always ready
    send(0, -9); send(0, -4); send(0, 16); send(0, 7);
    chk("t1_out_valid", 32'(ovld[0]), 1);
    chk("t1_acc", get_acc(0), 10);
    chk("t1_ovf", 32'(ovf[0]), 0);
    step();
    chk("t1_valid_drop", 32'(ovld[0]), 0);

    // consumer stalls for 5 cycles with the next term already offered
    ordy[0] = 1'b0;
    send(0, -9); send(0, -4); send(0, 16); send(0, 7);
    vld[0] = 1'b1; prod[0] = 8'(3);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t2_acc_stable", get_acc(0), 10);
      chk("t2_in_ready", 32'(irdy[0]), 0);
    end
    ordy[0] = 1'b1;
    step();
    chk("t2_no_accept_on_handshake", get_acc(0), 0);
    step();
    chk("t2_next_accept", get_acc(0), 3);
    vld[0] = 1'b0; clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;

    // clear mid-result drops the partial sum and the offered term
    send(0, 5); send(0, -3);
    clr[0] = 1'b1; vld[0] = 1'b1; prod[0] = 8'(99);
    step();
    clr[0] = 1'b0; vld[0] = 1'b0;
    chk("t3_clear_acc", get_acc(0), 0);
    send(0, 1); send(0, 1); send(0, 1); send(0, 1);
    chk("t3_acc", get_acc(0), 4);
    step();

    // reset while holding a result
    ordy[0] = 1'b0;
    send(0, 2); send(0, 2); send(0, 2); send(0, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t4_out_valid", 32'(ovld[0]), 0);
    chk("t4_in_ready", 32'(irdy[0]), 1);
    ordy[0] = 1'b1;
    send(0, 1); send(0, 2); send(0, 3); send(0, 4);
    chk("t4_acc", get_acc(0), 10);
    step();

    // 8-bit accumulator overflow
    ordy[1] = 1'b0;
    send(1, 64); send(1, 64); send(1, 64); send(1, 64);
`ifdef BOOTH_MAC_SAT_EN
    chk("t5_acc", get_acc(1), 127);
    chk("t5_ovf", 32'(ovf[1]), 1);
`else
    chk("t5_acc", get_acc(1), 0);
    chk("t5_ovf", 32'(ovf[1]), 0);
`endif
    ordy[1] = 1'b1;
    step();

    // single-term results back to back at the range limits
    send(2, -128);
    chk("t6_acc_min", get_acc(2), -128);
    chk("t6_in_ready_low", 32'(irdy[2]), 0);
    send(2, 127);
    chk("t6_acc_max", get_acc(2), 127);
    chk("t6_valid", 32'(ovld[2]), 1);
    step();

    // randomized traffic on all three instances
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < 3; i++) begin
        clr[i]  = ($urandom_range(0, 39) == 0);
        ordy[i] = ($urandom_range(0, 9) < 7);
        if (!pend[i]) begin
          vld[i]  = ($urandom_range(0, 9) < 7);
          prod[i] = 8'(rand_term());
        end
      end
      step();
      for (int i = 0; i < 3; i++)
        pend[i] = vld[i] && !took[i] && !rst && !clr[i];
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
